rs_syndrome_horner_ctrl: RTL and testbench

Sequencer that computes one Reed-Solomon syndrome by Horner's rule. It drives a single constant-operand GF(2^m) multiply, `gf_mult_a_by_b_const`, with `acc_next = gf_mult_a_by_b_const(acc, root) ^ symbol` over an n-symbol codeword. It sits between the codeword input stream and the decoder's key-equation stage. It owns framing, symbol counting, root latching and the output handshake.

---
 rtl/rs_syndrome_horner_ctrl.sv | 121 ++++++++++++
 tb/tb_rs_syndrome_horner_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_horner_ctrl.sv
// Horner-rule sequencer for one Reed-Solomon syndrome over GF(2^m).
// Frames start on isop. The result is held with oval until iordy.
module rs_syndrome_horner_ctrl #(
   parameter int unsigned m      = 8,
   parameter int unsigned irrpol = 285,
   parameter int unsigned n      = 255
) (
   input  logic         iclk,
   input  logic         ireset_n,
   input  logic [m-1:0] iroot,
   input  logic         ival,
   input  logic         isop,
   input  logic [m-1:0] idat,
   output logic         oready,
   output logic         oval,
   output logic [m-1:0] osyndrome,
   output logic         ozero,
   output logic         oabort,
   input  logic         iordy
);

   localparam int unsigned cw = $clog2(n + 1);
   localparam logic [m-1:0] polylow = m'(irrpol);

   // Shift-and-add multiply with reduction folded into each doubling of a.
   function automatic logic [m-1:0] gf_mult_a_by_b_const(input logic [m-1:0] a,
                                                         input logic [m-1:0] b);
      logic [m-1:0] p;
      logic [m-1:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < m; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[m-1] ? ((aa << 1) ^ polylow) : (aa << 1);
      end
      return p;
   endfunction

   typedef enum logic [1:0] {s_idle, s_acc, s_hold} state_t;

   state_t        state, state_d;
   logic [m-1:0]  acc, acc_d;
   logic [m-1:0]  root_r, root_d;
   logic [cw-1:0] cnt, cnt_d;
   logic [m-1:0]  syn_d;
   logic          zero_d;
   logic          abort_d;
   logic [m-1:0]  acc_step;
   logic [cw-1:0] cnt_inc;
   logic          accept;

   assign oready = (state != s_hold);
   assign oval   = (state == s_hold);

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state     <= s_idle;
         acc       <= '0;
         root_r    <= '0;
         cnt       <= '0;
         osyndrome <= '0;
         ozero     <= 1'b0;
         oabort    <= 1'b0;
      end else begin
         state     <= state_d;
         acc       <= acc_d;
         root_r    <= root_d;
         cnt       <= cnt_d;
         osyndrome <= syn_d;
         ozero     <= zero_d;
         oabort    <= abort_d;
      end
   end

   always_comb begin
      state_d  = state;
      acc_d    = acc;
      root_d   = root_r;
      cnt_d    = cnt;
      syn_d    = osyndrome;
      zero_d   = ozero;
      abort_d  = 1'b0;
      accept   = ival & oready;
      acc_step = gf_mult_a_by_b_const(acc, root_r) ^ idat;
      cnt_inc  = cnt + cw'(1);
      case (state)
         s_idle: begin
            if (accept && isop) begin
               acc_d   = idat;
               root_d  = iroot;
               cnt_d   = cw'(1);
               state_d = s_acc;
            end
         end
         s_acc: begin
            if (accept) begin
               if (isop) begin
                  // Mid-frame sop restarts the frame; n >= 2 keeps us in s_acc.
                  abort_d = 1'b1;
                  acc_d   = idat;
                  root_d  = iroot;
                  cnt_d   = cw'(1);
               end else begin
                  acc_d = acc_step;
                  cnt_d = cnt_inc;
                  if (cnt_inc == cw'(n)) begin
                     syn_d   = acc_step;
                     zero_d  = (acc_step == '0);
                     state_d = s_hold;
                  end
               end
            end
         end
         s_hold: begin
            if (iordy) state_d = s_idle;
         end
         default: state_d = s_idle;
      endcase
   end

endmodule

// File: tb/tb_rs_syndrome_horner_ctrl.sv
// Bench for rs_syndrome_horner_ctrl: dut 0 has n=2, dut 1 has n=4, GF(2^8)/285.
// Expected syndromes come from vector constants or a power-sum field model.
module tb_rs_syndrome_horner_ctrl;

   logic       iclk = 1'b0;
   logic       ireset_n;
   logic [7:0] iroot [2];
   logic       ival [2];
   logic       isop [2];
   logic [7:0] idat [2];
   logic       iordy [2];
   logic       oready [2];
   logic       oval [2];
   logic [7:0] osyn [2];
   logic       ozero [2];
   logic       oabort [2];

   int passed = 0;
   int total  = 0;
   int ab0    = 0;
   int ab1    = 0;

   typedef struct {
      int         d;
      logic [7:0] root;
      logic [7:0] s [4];
      logic       chg;
      logic [7:0] es;
      logic       ez;
   } vec_t;

   typedef struct {
      int         d;
      logic [7:0] s;
      logic       z;
   } exp_t;

   exp_t sb [$];

   always #5 iclk = ~iclk;

   rs_syndrome_horner_ctrl #(.m(8), .irrpol(285), .n(2)) u_n2 (
      .iclk(iclk), .ireset_n(ireset_n), .iroot(iroot[0]), .ival(ival[0]),
      .isop(isop[0]), .idat(idat[0]), .oready(oready[0]), .oval(oval[0]),
      .osyndrome(osyn[0]), .ozero(ozero[0]), .oabort(oabort[0]), .iordy(iordy[0]));

   rs_syndrome_horner_ctrl #(.m(8), .irrpol(285), .n(4)) u_n4 (
      .iclk(iclk), .ireset_n(ireset_n), .iroot(iroot[1]), .ival(ival[1]),
      .isop(isop[1]), .idat(idat[1]), .oready(oready[1]), .oval(oval[1]),
      .osyndrome(osyn[1]), .ozero(ozero[1]), .oabort(oabort[1]), .iordy(iordy[1]));

   always @(negedge iclk) begin
      if (oabort[0] === 1'b1) ab0++;
      if (oabort[1] === 1'b1) ab1++;
   end

   function automatic int nlen(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   // Full carry-less product, then reduction from the top bit down.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      logic [15:0] poly;
      p = '0;
      poly = 16'd285;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (poly << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] model(input logic [7:0] s [4], input int len,
                                        input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] pw;
      acc = '0;
      for (int i = 0; i < len; i++) begin
         pw = 8'h01;
         for (int j = 0; j < len - 1 - i; j++) pw = gmul(pw, b);
         acc = acc ^ gmul(s[i], pw);
      end
      return acc;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic drive_sym(input int d, input logic sop, input logic [7:0] dat,
                            input logic [7:0] root);
      ival[d]  = 1'b1;
      isop[d]  = sop;
      idat[d]  = dat;
      iroot[d] = root;
      @(posedge iclk); #1;
      ival[d] = 1'b0;
      isop[d] = 1'b0;
   endtask

   task automatic check_result(input int d);
      exp_t e;
      for (int t = 0; t < 20 && oval[d] !== 1'b1; t++) begin
         @(posedge iclk); #1;
      end
      if (oval[d] !== 1'b1) begin
         total++;
         $display("FAIL oval_timeout: got %0b expected 1", oval[d]);
      end else if (sb.size() == 0) begin
         total++;
         $display("FAIL sb_empty: got result %0h expected none", osyn[d]);
      end else begin
         e = sb.pop_front();
         chk("sb_dut", d, e.d);
         chk("syndrome", osyn[d], e.s);
         chk("zero", ozero[d], e.z);
      end
   endtask

   // Drives a whole frame without bubbles; the result must be up right after the last edge.
   task automatic run_frame(input int d, input logic [7:0] s [4], input logic [7:0] root,
                            input logic chg);
      int len;
      len = nlen(d);
      for (int k = 0; k < len; k++)
         drive_sym(d, k == 0, s[k], (k == 0 || !chg) ? root : 8'h04);
      chk("latency_oval", oval[d], 1'b1);
      check_result(d);
      @(posedge iclk); #1;
      chk("post_hold_oval", oval[d], 1'b0);
      chk("post_hold_ready", oready[d], 1'b1);
   endtask

   vec_t       tbl [5];
   logic [7:0] rs [4];
   logic [7:0] rr;
   int         rd;

   initial begin
      tbl[0] = '{0, 8'h02, '{8'h01, 8'h01, 8'h00, 8'h00}, 1'b0, 8'h03, 1'b0};
      tbl[1] = '{0, 8'h02, '{8'h80, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h1D, 1'b0};
      tbl[2] = '{1, 8'h02, '{8'h01, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h08, 1'b0};
      tbl[3] = '{1, 8'h02, '{8'h01, 8'h00, 8'h00, 8'h00}, 1'b1, 8'h08, 1'b0};
      tbl[4] = '{0, 8'h02, '{8'h03, 8'h06, 8'h00, 8'h00}, 1'b0, 8'h00, 1'b1};

      ireset_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ival[d] = 1'b0; isop[d] = 1'b0; idat[d] = '0; iroot[d] = '0; iordy[d] = 1'b1;
      end
      #2 ireset_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_oval", oval[d], 1'b0);
         chk("rst_ready", oready[d], 1'b1);
         chk("rst_syn", osyn[d], 8'h00);
         chk("rst_zero", ozero[d], 1'b0);
         chk("rst_abort", oabort[d], 1'b0);
      end
      repeat (2) @(negedge iclk);
      ireset_n = 1'b1;
      @(posedge iclk); #1;

      for (int i = 0; i < 5; i++) begin
         sb.push_back('{tbl[i].d, tbl[i].es, tbl[i].ez});
         run_frame(tbl[i].d, tbl[i].s, tbl[i].root, tbl[i].chg);
      end

      for (int i = 0; i < 6; i++) begin
         rd = $urandom_range(0, 1);
         rr = 8'($urandom_range(1, 255));
         for (int k = 0; k < 4; k++) rs[k] = 8'($urandom_range(0, 255));
         rr = model(rs, nlen(rd), rr) ^ model(rs, nlen(rd), rr) ^ rr;
         sb.push_back('{rd, model(rs, nlen(rd), rr), model(rs, nlen(rd), rr) == 8'h00});
         run_frame(rd, rs, rr, 1'b0);
      end

      // Restart mid-frame on the n=4 instance.
      drive_sym(1, 1'b1, 8'h05, 8'h02);
      drive_sym(1, 1'b0, 8'h07, 8'h02);
      chk("abort_before", oabort[1], 1'b0);
      sb.push_back('{1, 8'h08, 1'b0});
      drive_sym(1, 1'b1, 8'h01, 8'h02);
      chk("abort_pulse", oabort[1], 1'b1);
      drive_sym(1, 1'b0, 8'h00, 8'h02);
      chk("abort_one_cycle", oabort[1], 1'b0);
      drive_sym(1, 1'b0, 8'h00, 8'h02);
      chk("abort_no_early_oval", oval[1], 1'b0);
      drive_sym(1, 1'b0, 8'h00, 8'h02);
      check_result(1);
      @(posedge iclk); #1;

      // Hold with iordy low while a symbol waits upstream.
      iordy[0] = 1'b0;
      sb.push_back('{0, 8'h00, 1'b1});
      drive_sym(0, 1'b1, 8'h03, 8'h02);
      drive_sym(0, 1'b0, 8'h06, 8'h02);
      ival[0] = 1'b1; isop[0] = 1'b1; idat[0] = 8'h55;
      for (int c = 0; c < 5; c++) begin
         chk("hold_oval", oval[0], 1'b1);
         chk("hold_syn", osyn[0], 8'h00);
         chk("hold_zero", ozero[0], 1'b1);
         chk("hold_ready", oready[0], 1'b0);
         @(posedge iclk); #1;
      end
      ival[0] = 1'b0; isop[0] = 1'b0;
      iordy[0] = 1'b1;
      check_result(0);
      @(posedge iclk); #1;
      chk("hold_exit_oval", oval[0], 1'b0);
      chk("hold_exit_ready", oready[0], 1'b1);

      // Non-sop symbols in IDLE must be dropped.
      drive_sym(0, 1'b0, 8'h77, 8'h02);
      drive_sym(0, 1'b0, 8'h77, 8'h02);
      drive_sym(0, 1'b0, 8'h77, 8'h02);
      chk("idle_nonsop_oval", oval[0], 1'b0);
      sb.push_back('{0, 8'h03, 1'b0});
      rs = '{8'h01, 8'h01, 8'h00, 8'h00};
      run_frame(0, rs, 8'h02, 1'b0);

      // Reset in the middle of an n=4 frame.
      drive_sym(1, 1'b1, 8'h09, 8'h02);
      drive_sym(1, 1'b0, 8'h02, 8'h02);
      #2 ireset_n = 1'b0;
      #1;
      chk("mid_rst_oval", oval[1], 1'b0);
      chk("mid_rst_ready", oready[1], 1'b1);
      chk("mid_rst_syn", osyn[1], 8'h00);
      chk("mid_rst_zero", ozero[1], 1'b0);
      chk("mid_rst_abort", oabort[1], 1'b0);
      @(negedge iclk);
      ireset_n = 1'b1;
      @(posedge iclk); #1;
      rs = '{8'h01, 8'h02, 8'h03, 8'h04};
      sb.push_back('{1, model(rs, 4, 8'h02), model(rs, 4, 8'h02) == 8'h00});
      run_frame(1, rs, 8'h02, 1'b0);

      chk("abort_count_n4", ab1, 1);
      chk("abort_count_n2", ab0, 0);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
